rv32_dbus_bridge: RTL

- Downstream neighbour of the RV32I core's data memory port. Consumes daddress/dread/dwrite/dwritedata/dbyteenable and returns dreaddata/dwaitrequest.
- Converts core accesses into a pipelined Avalon-MM master with variable read latency (readdatavalid). Core stores are posted through a write FIFO.
- Decodes a local timer window and drives the core's wr_mtime/wr_mtimecmp/wr_mtime_upper/wr_mtime_val update inputs.

---
 rtl/rv32_dbus_bridge.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/rv32_dbus_bridge.sv
// rv32_dbus_bridge: RV32I data port -> pipelined Avalon-MM master.
// Stores are posted through a small FIFO; loads drain the FIFO first so a
// load never overtakes an older store. Stores into the 16-byte timer window
// bypass the bus and become one-cycle mtime/mtimecmp update pulses.
module rv32_dbus_bridge #(
   parameter int          WFIFO_LOG2 = 2,
   parameter logic [31:0] TIMER_BASE = 32'hAFFFFFE0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           daddress,
   input  logic                  dwrite,
   input  logic [31:0]           dwritedata,
   input  logic [3:0]            dbyteenable,
   input  logic                  dread,
   output logic [31:0]           dreaddata,
   output logic                  dwaitrequest,
   output logic [31:0]           avm_address,
   output logic                  avm_write,
   output logic [31:0]           avm_writedata,
   output logic [3:0]            avm_byteenable,
   output logic                  avm_read,
   input  logic [31:0]           avm_readdata,
   input  logic                  avm_readdatavalid,
   input  logic                  avm_waitrequest,
   output logic                  wr_mtime,
   output logic                  wr_mtimecmp,
   output logic                  wr_mtime_upper,
   output logic [31:0]           wr_mtime_val,
   output logic [WFIFO_LOG2:0]   wfifo_level,
   output logic                  overflow_err
);

   localparam int DEPTH = 1 << WFIFO_LOG2;

   typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_RD_REQ, S_RD_WAIT, S_RD_RTN} state_t;

   state_t                r_state, w_next;
   logic [31:0]           r_fa [DEPTH];
   logic [31:0]           r_fd [DEPTH];
   logic [3:0]            r_fb [DEPTH];
   logic [WFIFO_LOG2-1:0] r_wptr, r_rptr;
   logic [WFIFO_LOG2:0]   r_count;
   logic                  r_ovf;
   logic [31:0]           r_rdata;
   logic                  r_tw, r_tc, r_tu;
   logic [31:0]           r_tv;

   logic w_timer, w_empty, w_full, w_rd_busy, w_wr_vld;
   logic w_pop, w_push_req, w_push;

   assign w_timer    = (daddress[31:4] == TIMER_BASE[31:4]);
   assign w_empty    = (r_count == '0);
   // count never exceeds DEPTH, so the MSB alone marks "full"
   assign w_full     = r_count[WFIFO_LOG2];
   assign w_rd_busy  = (r_state == S_RD_REQ) || (r_state == S_RD_WAIT);
   assign w_wr_vld   = ~w_empty & ~w_rd_busy;
   assign w_pop      = w_wr_vld & ~avm_waitrequest;
   assign w_push_req = dwrite & ~w_timer;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign w_push     = w_push_req & (~w_full | w_pop);

   assign wfifo_level    = r_count;
   assign overflow_err   = r_ovf;
   assign wr_mtime       = r_tw;
   assign wr_mtimecmp    = r_tc;
   assign wr_mtime_upper = r_tu;
   assign wr_mtime_val   = r_tv;
   assign dwaitrequest   = dread & (r_state != S_RD_RTN);

   // posted-write FIFO storage, pointers and occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_fa[i] <= '0;
            r_fd[i] <= '0;
            r_fb[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_fa[r_wptr] <= daddress;
            r_fd[r_wptr] <= dwritedata;
            r_fb[r_wptr] <= dbyteenable;
            r_wptr       <= r_wptr + 1'b1;
         end
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // sticky drop flag: store arrived with no room and no pop to make room
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                             r_ovf <= 1'b0;
      else if (w_push_req & w_full & ~w_pop) r_ovf <= 1'b1;
   end

   // timer-window stores become registered one-cycle update pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tw <= 1'b0;
         r_tc <= 1'b0;
         r_tu <= 1'b0;
         r_tv <= '0;
      end else begin
         r_tw <= dwrite & w_timer & ~daddress[3];
         r_tc <= dwrite & w_timer &  daddress[3];
         r_tu <= dwrite & w_timer &  daddress[2];
         r_tv <= (dwrite & w_timer) ? dwritedata : '0;
      end
   end

   // load data capture: timer window reads as zero, bus reads from readdata
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                            r_rdata <= '0;
      else if (r_state == S_IDLE && dread && w_timer)       r_rdata <= '0;
      else if (r_state == S_RD_WAIT && avm_readdatavalid)   r_rdata <= avm_readdata;
   end

   // load FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // load FSM next state; DRAIN is skipped when it would have nothing to wait on
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (dread) begin
                       if (w_timer)                 w_next = S_RD_RTN;
                       else if (w_empty & ~w_push)  w_next = S_RD_REQ;
                       else                         w_next = S_DRAIN;
                    end
         S_DRAIN:   if (w_empty & ~w_push_req)      w_next = S_RD_REQ;
         S_RD_REQ:  if (~avm_waitrequest)           w_next = S_RD_WAIT;
         S_RD_WAIT: if (avm_readdatavalid)          w_next = S_RD_RTN;
         S_RD_RTN:                                  w_next = S_IDLE;
         default:                                   w_next = S_IDLE;
      endcase
   end

   // Avalon command and core read-data outputs; reads own the bus in RD_REQ
   always_comb begin
      avm_read       = 1'b0;
      avm_write      = 1'b0;
      avm_address    = '0;
      avm_writedata  = '0;
      avm_byteenable = '0;
      dreaddata      = '0;
      if (r_state == S_RD_REQ) begin
         avm_read       = 1'b1;
         avm_address    = daddress;
         avm_byteenable = 4'hF;
      end else if (w_wr_vld) begin
         avm_write      = 1'b1;
         avm_address    = r_fa[r_rptr];
         avm_writedata  = r_fd[r_rptr];
         avm_byteenable = r_fb[r_rptr];
      end
      if (r_state == S_RD_RTN) dreaddata = r_rdata;
   end

endmodule
